// File: rtl/odbus_arbiter_if.sv
//------------------------------------------------------------------------------
// odbus_arbiter_if : request/grant/drive bundle between requesters and arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface odbus_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic [N-1:0] drive_en;
    logic         busy;
    logic         settling;
    logic         timeout;

    modport master (
        output req, done,
        input  gnt, drive_en, busy, settling, timeout
    );

    modport slave (
        input  req, done,
        output gnt, drive_en, busy, settling, timeout
    );
endinterface

`default_nettype wire

// File: rtl/odbus_arbiter.sv
//------------------------------------------------------------------------------
// odbus_arbiter : round-robin open-drain bus arbiter with post-release settle
// Optional ODBUS_TIMEOUT_EN: revoke a grant after MAX_HOLD drive cycles.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module odbus_arbiter #(
    parameter int N             = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int MAX_HOLD      = 64
) (
    input  logic           clk,
    input  logic           rst,
    odbus_arbiter_if.slave bus
);
    localparam int c_iw = $clog2(N);
    localparam int c_cw = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [c_iw-1:0] c_last   = c_iw'(N - 1);
    localparam logic [c_cw-1:0] c_settle = c_cw'(SETTLE_CYCLES);

    if (N < 2 || N > 8 || MAX_HOLD < 1 || SETTLE_CYCLES < 0) begin : g_param_check
        $error("odbus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_DRIVE  = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t          r_state, w_state;
    logic [c_iw-1:0] r_ptr, w_ptr;
    logic [c_iw-1:0] r_win, w_win;
    logic [c_iw-1:0] w_pick, w_scan;
    logic [c_cw-1:0] r_cnt, w_cnt;
    logic [N-1:0]    r_gnt, w_gnt;
    logic [N-1:0]    r_drive_en, w_drive_en;
    logic            r_busy, w_busy;
    logic            r_settling, w_settling;
    logic            w_release;
    logic            w_force;

`ifdef ODBUS_TIMEOUT_EN
    localparam int c_hw = $clog2(MAX_HOLD + 1);
    localparam logic [c_hw-1:0] c_hold_last = c_hw'(MAX_HOLD - 1);
    logic [c_hw-1:0] r_hold, w_hold;
    logic            r_timeout;
`endif

    always_comb begin
        w_state    = r_state;
        w_ptr      = r_ptr;
        w_win      = r_win;
        w_cnt      = r_cnt;
        w_pick     = r_ptr;
        w_scan     = r_ptr;
        w_release  = bus.done[r_win] || !bus.req[r_win];
        w_force    = 1'b0;
`ifdef ODBUS_TIMEOUT_EN
        w_hold     = r_hold;
        w_force    = !w_release && (r_hold == c_hold_last);
`endif

        // Walk offsets from farthest to nearest so the nearest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            w_scan = c_iw'((int'(r_ptr) + i) % N);
            if (bus.req[w_scan]) begin
                w_pick = w_scan;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (|bus.req) begin
                    w_win   = w_pick;
                    w_state = S_GRANT;
                end
            end
            S_GRANT: begin
                // Requester gave up before the gate was enabled: no settle needed.
                if (bus.req[r_win]) begin
                    w_state = S_DRIVE;
`ifdef ODBUS_TIMEOUT_EN
                    w_hold  = '0;
`endif
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_DRIVE: begin
`ifdef ODBUS_TIMEOUT_EN
                w_hold = r_hold + c_hw'(1);
`endif
                if (w_release || w_force) begin
                    w_ptr = (r_win == c_last) ? '0 : r_win + c_iw'(1);
                    if (SETTLE_CYCLES == 0) begin
                        w_state = S_IDLE;
                    end else begin
                        w_state = S_SETTLE;
                        w_cnt   = c_settle;
                    end
                end
            end
            S_SETTLE: begin
                if (r_cnt <= c_cw'(1)) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end else begin
                    w_cnt   = r_cnt - c_cw'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase

        w_gnt      = '0;
        w_drive_en = '0;
        if (w_state == S_GRANT || w_state == S_DRIVE) begin
            w_gnt[w_win] = 1'b1;
        end
        if (w_state == S_DRIVE) begin
            w_drive_en[w_win] = 1'b1;
        end
        w_busy     = (w_state == S_GRANT) || (w_state == S_DRIVE);
        w_settling = (w_state == S_SETTLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_win      <= '0;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_drive_en <= '0;
            r_busy     <= 1'b0;
            r_settling <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_ptr      <= w_ptr;
            r_win      <= w_win;
            r_cnt      <= w_cnt;
            r_gnt      <= w_gnt;
            r_drive_en <= w_drive_en;
            r_busy     <= w_busy;
            r_settling <= w_settling;
        end
    end

`ifdef ODBUS_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_hold    <= w_hold;
            r_timeout <= (r_state == S_DRIVE) && w_force;
        end
    end
    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt      = r_gnt;
    assign bus.drive_en = r_drive_en;
    assign bus.busy     = r_busy;
    assign bus.settling = r_settling;

endmodule

`default_nettype wire
